psr_cc_unit: RTL and testbench
==============================

Name: psr_cc_unit

Overview:
Processor State Register stage directly downstream of the 32-bit ALU. It consumes the ALU N/Z/C/V flags and latches them into the integer condition codes (icc) on flag-setting ops. It feeds the stored C back as the ALU carry input and evaluates SPARC Bicc branch conditions. It also owns CWP/S/PS/ET, SAVE/RESTORE window rotation with WIM overflow/underflow detection, and trap entry/return state.

Parameters:
NWINDOWS, 8, number of register windows (2..32); CWP range 0..NWINDOWS-1
IMPL, 4'h0, PSR impl field [31:28], read-only
VER, 4'h0, PSR ver field [27:24], read-only

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high
icc_we  in  1  latch ALU flags this cycle (opcode S bit set)
alu_n  in  1  ALU N flag
alu_z  in  1  ALU Z flag
alu_c  in  1  ALU C flag
alu_v  in  1  ALU V flag
carry_out  out  1  current icc.C to ALU carry input
cond  in  4  Bicc cond field
branch_taken  out  1  cond evaluated against icc
save  in  1  SAVE request
restore  in  1  RESTORE request
wim  in  NWINDOWS  window invalid mask
wr_psr  in  1  WRPSR strobe
wr_data  in  32  WRPSR data
trap_enter  in  1  trap taken
rett  in  1  return from trap
psr  out  32  assembled PSR
win_overflow  out  1  one-cycle pulse, SAVE hit invalid window
win_underflow  out  1  one-cycle pulse, RESTORE hit invalid window
illegal_wr  out  1  one-cycle pulse, WRPSR CWP >= NWINDOWS
error_mode  out  1  sticky, trap_enter while ET=0

Behaviour:
- Interface: one clock (clk). reset is synchronous and active-high.
- Reset values: icc=0000; PIL=0; S=1; PS=0; ET=0; CWP=0. All pulse outputs are 0, error_mode=0.
- Reset values (cont.): psr = {IMPL,VER,4'b0,6'b0,1'b0,1'b0,4'b0,1,0,0,5'b0}.
- PSR layout: [31:28] IMPL, [27:24] VER, [23:20] N Z V C, [19:12] zero, [11:8] PIL, [7] S, [6] PS, [5] ET, [4:0] CWP. CWP is zero-extended.
- Timing: all state updates take effect one cycle after the strobe. branch_taken and carry_out are combinational from the registered icc, so a flag-setting op affects a branch evaluated the next cycle.
- Control priority per cycle: reset > trap_enter > rett > wr_psr > save/restore.
- icc update: applied independently of CWP actions. The exception is wr_psr, which writes icc from wr_data[23:20] and overrides icc_we in that cycle.
- trap_enter:
  - ET=1: CWP=(CWP-1) mod NWINDOWS, PS=S, S=1, ET=0.
  - ET=0: no state change; error_mode is set and stays set until reset.
- rett: CWP=(CWP+1) mod NWINDOWS, S=PS, ET=1. No WIM check.
- wr_psr:
  - If wr_data[4:0] < NWINDOWS: load icc, PIL, S, PS, ET, CWP from wr_data.
  - Otherwise: no state change and illegal_wr is pulsed.
- save: new=(CWP-1) mod NWINDOWS, wrapping 0 to NWINDOWS-1. If wim[new]=1, CWP is unchanged and win_overflow is pulsed; otherwise CWP=new.
- restore: new=(CWP+1) mod NWINDOWS, wrapping NWINDOWS-1 to 0. If wim[new]=1, CWP is unchanged and win_underflow is pulsed; otherwise CWP=new.
- save and restore in the same cycle: no CWP change, no pulses.
- Bicc conditions: 0 never; 1 Z; 2 Z|(N^V); 3 N^V; 4 C|Z; 5 C; 6 N; 7 V; 8 always. 9..F are the complements of 1..7 (9=!Z … F=!V).
- Reset mid-sequence: pending pulses are cleared the same edge. No partial CWP update survives.

Optional Feature:
PSR_BYPASS_EN
- Defined: when icc_we=1, branch_taken and carry_out use the live alu_n/z/c/v instead of the registered icc, giving zero-cycle flag forwarding. The registered update is unchanged.
- Undefined: registered icc only, with one-cycle flag-to-branch latency.

Decomposition:
- Package sparc_pkg: Bicc cond localparams (COND_BN..COND_BVC), PSR field bit-index constants, packed icc struct {n,z,v,c}.
- Sub-module branch_cond_eval: combinational cond + icc -> taken, instantiated once.

Test Plan:
1. Reset held 2 cycles -> psr=32'h0000_0080, carry_out=0, branch_taken=0 for cond=1 (BE), error_mode=0.
2. icc_we with N=0,Z=1,C=1,V=0 -> next cycle psr[23:20]=4'b0101, carry_out=1; cond=1 taken, cond=9 not taken, cond=4 taken.
3. NWINDOWS=8, CWP=0, wim=8'h80, save -> CWP unchanged, win_overflow pulses 1 cycle. Then wim=0, save -> CWP=7; restore -> CWP=0.
4. ET=1, S=0, CWP=3, trap_enter -> CWP=2, PS=0, S=1, ET=0. rett -> CWP=3, S=0, ET=1. A second trap_enter issued while ET=0 -> error_mode=1 and remains until reset.
5. wr_psr data=32'h00F0_0FA5 -> icc=F, PIL=F, S=1, PS=0, ET=1, CWP=5. wr_psr with CWP=9 -> illegal_wr pulse, PSR unchanged. wr_psr together with icc_we -> wr_data icc wins.
6. save+restore in the same cycle -> no change, no pulses. With PSR_BYPASS_EN defined, icc_we with alu_z=1 and cond=1 -> branch_taken=1 in the same cycle.

Source files
------------

// File: rtl/sparc_pkg.sv
// Shared SPARC definitions: Bicc condition codes, PSR bit positions and the icc flag struct.
package sparc_pkg;

  localparam logic [3:0] COND_BN   = 4'h0;
  localparam logic [3:0] COND_BE   = 4'h1;
  localparam logic [3:0] COND_BLE  = 4'h2;
  localparam logic [3:0] COND_BL   = 4'h3;
  localparam logic [3:0] COND_BLEU = 4'h4;
  localparam logic [3:0] COND_BCS  = 4'h5;
  localparam logic [3:0] COND_BNEG = 4'h6;
  localparam logic [3:0] COND_BVS  = 4'h7;
  localparam logic [3:0] COND_BA   = 4'h8;
  localparam logic [3:0] COND_BNE  = 4'h9;
  localparam logic [3:0] COND_BG   = 4'hA;
  localparam logic [3:0] COND_BGE  = 4'hB;
  localparam logic [3:0] COND_BGU  = 4'hC;
  localparam logic [3:0] COND_BCC  = 4'hD;
  localparam logic [3:0] COND_BPOS = 4'hE;
  localparam logic [3:0] COND_BVC  = 4'hF;

  localparam int PSR_ICC_LSB = 20;
  localparam int PSR_PIL_LSB = 8;
  localparam int PSR_S_BIT   = 7;
  localparam int PSR_PS_BIT  = 6;
  localparam int PSR_ET_BIT  = 5;

  // Field order matches PSR[23:20] so a 4-bit slice casts straight into it.
  typedef struct packed {
    logic n;
    logic z;
    logic v;
    logic c;
  } icc_t;

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational Bicc evaluator: conditions 9..F are the complements of 1..7.
module branch_cond_eval
  import sparc_pkg::*;
(
  input  logic [3:0] cond,
  input  icc_t       icc,
  output logic       taken
);

  logic base;

  always_comb begin
    base = 1'b0;
    case (cond[2:0])
      3'd0: base = 1'b0;
      3'd1: base = icc.z;
      3'd2: base = icc.z | (icc.n ^ icc.v);
      3'd3: base = icc.n ^ icc.v;
      3'd4: base = icc.c | icc.z;
      3'd5: base = icc.c;
      3'd6: base = icc.n;
      3'd7: base = icc.v;
      default: base = 1'b0;
    endcase
  end

  assign taken = base ^ cond[3];

endmodule

// File: rtl/psr_cc_unit.sv
// SPARC PSR stage: icc latch, branch evaluation, window rotation and trap state.
// Optional macro PSR_BYPASS_EN forwards live ALU flags to branch_taken/carry_out.
module psr_cc_unit
  import sparc_pkg::*;
#(
  parameter int         NWINDOWS = 8,
  parameter logic [3:0] IMPL     = 4'h0,
  parameter logic [3:0] VER      = 4'h0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                icc_we,
  input  logic                alu_n,
  input  logic                alu_z,
  input  logic                alu_c,
  input  logic                alu_v,
  output logic                carry_out,
  input  logic [3:0]          cond,
  output logic                branch_taken,
  input  logic                save,
  input  logic                restore,
  input  logic [NWINDOWS-1:0] wim,
  input  logic                wr_psr,
  input  logic [31:0]         wr_data,
  input  logic                trap_enter,
  input  logic                rett,
  output logic [31:0]         psr,
  output logic                win_overflow,
  output logic                win_underflow,
  output logic                illegal_wr,
  output logic                error_mode
);

  icc_t       icc;
  icc_t       alu_icc;
  icc_t       eval_icc;
  logic [3:0] pil;
  logic       s;
  logic       ps;
  logic       et;
  logic [4:0] cwp;

  logic [4:0]          cwp_dec;
  logic [4:0]          cwp_inc;
  logic [NWINDOWS-1:0] wim_dec_sh;
  logic [NWINDOWS-1:0] wim_inc_sh;
  logic                wr_cwp_ok;

  assign alu_icc = '{n: alu_n, z: alu_z, v: alu_v, c: alu_c};

  assign cwp_dec    = (cwp == 5'd0) ? 5'(NWINDOWS - 1) : cwp - 5'd1;
  assign cwp_inc    = (cwp == 5'(NWINDOWS - 1)) ? 5'd0 : cwp + 5'd1;
  // Shift rather than index so the select width never depends on NWINDOWS.
  assign wim_dec_sh = wim >> cwp_dec;
  assign wim_inc_sh = wim >> cwp_inc;
  assign wr_cwp_ok  = {27'd0, wr_data[4:0]} < 32'(NWINDOWS);

`ifdef PSR_BYPASS_EN
  assign eval_icc = icc_we ? alu_icc : icc;
`else
  assign eval_icc = icc;
`endif

  assign carry_out = eval_icc.c;

  branch_cond_eval u_branch_cond_eval (
    .cond  (cond),
    .icc   (eval_icc),
    .taken (branch_taken)
  );

  assign psr = {IMPL, VER, icc, 8'd0, pil, s, ps, et, cwp};

  always_ff @(posedge clk) begin
    if (reset) begin
      icc           <= '0;
      pil           <= 4'd0;
      s             <= 1'b1;
      ps            <= 1'b0;
      et            <= 1'b0;
      cwp           <= 5'd0;
      win_overflow  <= 1'b0;
      win_underflow <= 1'b0;
      illegal_wr    <= 1'b0;
      error_mode    <= 1'b0;
    end else begin
      win_overflow  <= 1'b0;
      win_underflow <= 1'b0;
      illegal_wr    <= 1'b0;

      // A WRPSR that wins arbitration owns the icc this cycle, legal or not.
      if (icc_we && !(wr_psr && !trap_enter && !rett))
        icc <= alu_icc;

      if (trap_enter) begin
        if (et) begin
          cwp <= cwp_dec;
          ps  <= s;
          s   <= 1'b1;
          et  <= 1'b0;
        end else begin
          error_mode <= 1'b1;
        end
      end else if (rett) begin
        cwp <= cwp_inc;
        s   <= ps;
        et  <= 1'b1;
      end else if (wr_psr) begin
        if (wr_cwp_ok) begin
          icc <= icc_t'(wr_data[PSR_ICC_LSB +: 4]);
          pil <= wr_data[PSR_PIL_LSB +: 4];
          s   <= wr_data[PSR_S_BIT];
          ps  <= wr_data[PSR_PS_BIT];
          et  <= wr_data[PSR_ET_BIT];
          cwp <= wr_data[4:0];
        end else begin
          illegal_wr <= 1'b1;
        end
      end else if (save && !restore) begin
        if (wim_dec_sh[0]) win_overflow <= 1'b1;
        else               cwp <= cwp_dec;
      end else if (restore && !save) begin
        if (wim_inc_sh[0]) win_underflow <= 1'b1;
        else               cwp <= cwp_inc;
      end
    end
  end

endmodule

// File: tb/tb_psr_cc_unit.sv
// Scoreboard bench for psr_cc_unit: directed steps push expected outputs, a negedge monitor checks them.
module tb_psr_cc_unit;

`ifdef PSR_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        icc_we;
  logic        alu_n, alu_z, alu_c, alu_v;
  logic        carry_out;
  logic [3:0]  cond;
  logic        branch_taken;
  logic        save, restore;
  logic [7:0]  wim;
  logic        wr_psr;
  logic [31:0] wr_data;
  logic        trap_enter, rett;
  logic [31:0] psr;
  logic        win_overflow, win_underflow, illegal_wr, error_mode;

  psr_cc_unit #(.NWINDOWS(8), .IMPL(4'h0), .VER(4'h0)) dut (
    .clk           (clk),
    .reset         (reset),
    .icc_we        (icc_we),
    .alu_n         (alu_n),
    .alu_z         (alu_z),
    .alu_c         (alu_c),
    .alu_v         (alu_v),
    .carry_out     (carry_out),
    .cond          (cond),
    .branch_taken  (branch_taken),
    .save          (save),
    .restore       (restore),
    .wim           (wim),
    .wr_psr        (wr_psr),
    .wr_data       (wr_data),
    .trap_enter    (trap_enter),
    .rett          (rett),
    .psr           (psr),
    .win_overflow  (win_overflow),
    .win_underflow (win_underflow),
    .illegal_wr    (illegal_wr),
    .error_mode    (error_mode)
  );

  typedef struct packed {
    logic        rst;
    logic        we;
    logic        n, z, c, v;
    logic [3:0]  cnd;
    logic        sv, rs;
    logic [7:0]  wm;
    logic        wr;
    logic [31:0] wd;
    logic        trap, rt;
  } stim_t;

  typedef struct {
    string       name;
    int          due;
    logic [31:0] psr;
    logic        carry;
    logic        taken;
    logic [3:0]  flags;
  } exp_t;

  exp_t expq[$];
  int   cycle = 0;
  int   checks = 0;
  int   passed = 0;
  bit   stim_done = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cycle <= cycle + 1;

  function automatic stim_t idle();
    stim_t s;
    s = '0;
    return s;
  endfunction

  // Outputs given are those observed during the same cycle the inputs are driven.
  task automatic applyStimulus(input string nm, input stim_t s, input logic [31:0] e_psr,
                               input logic e_carry, input logic e_taken,
                               input logic e_ovf, input logic e_unf, input logic e_ill,
                               input logic e_err);
    exp_t e;
    reset = s.rst; icc_we = s.we;
    alu_n = s.n; alu_z = s.z; alu_c = s.c; alu_v = s.v;
    cond = s.cnd; save = s.sv; restore = s.rs; wim = s.wm;
    wr_psr = s.wr; wr_data = s.wd; trap_enter = s.trap; rett = s.rt;
    e.name = nm; e.due = cycle; e.psr = e_psr; e.carry = e_carry; e.taken = e_taken;
    e.flags = {e_ovf, e_unf, e_ill, e_err};
    expq.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic checkOne(input string nm, input string field,
                          input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s.%s: got %h expected %h", nm, field, act, exp);
  endtask

  task automatic checkOutput(input exp_t e);
    checkOne(e.name, "psr", psr, e.psr);
    checkOne(e.name, "carry_out", {31'd0, carry_out}, {31'd0, e.carry});
    checkOne(e.name, "branch_taken", {31'd0, branch_taken}, {31'd0, e.taken});
    checkOne(e.name, "ovf/unf/ill/err",
             {28'd0, win_overflow, win_underflow, illegal_wr, error_mode}, {28'd0, e.flags});
  endtask

  // Monitor: pops every expectation whose cycle has arrived.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (expq.size() > 0 && expq[0].due <= cycle) begin
        e = expq.pop_front();
        if (e.due < cycle) begin
          checks++;
          $display("[TB] FAIL %s: sampled late at cycle %0d expected %0d", e.name, cycle, e.due);
        end else begin
          checkOutput(e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    stim_t s;
    reset = 1'b1; icc_we = 1'b0; alu_n = 1'b0; alu_z = 1'b0; alu_c = 1'b0; alu_v = 1'b0;
    cond = 4'h0; save = 1'b0; restore = 1'b0; wim = 8'h00; wr_psr = 1'b0; wr_data = 32'h0;
    trap_enter = 1'b0; rett = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    s = idle(); s.rst = 1'b1; s.cnd = 4'h1;
    applyStimulus("rst_hold", s, 32'h0000_0080, 0, 0, 0, 0, 0, 0);

    s = idle(); s.we = 1'b1; s.z = 1'b1; s.c = 1'b1; s.cnd = 4'h1;
    applyStimulus("flags_set", s, 32'h0000_0080, BYP, BYP, 0, 0, 0, 0);
    s = idle(); s.cnd = 4'h1;
    applyStimulus("be_taken", s, 32'h0050_0080, 1, 1, 0, 0, 0, 0);
    s = idle(); s.cnd = 4'h9;
    applyStimulus("bne_not", s, 32'h0050_0080, 1, 0, 0, 0, 0, 0);
    s = idle(); s.cnd = 4'h4;
    applyStimulus("bleu_taken", s, 32'h0050_0080, 1, 1, 0, 0, 0, 0);
    s = idle(); s.cnd = 4'h3;
    applyStimulus("bl_not", s, 32'h0050_0080, 1, 0, 0, 0, 0, 0);
    s = idle(); s.cnd = 4'hA;
    applyStimulus("bg_not", s, 32'h0050_0080, 1, 0, 0, 0, 0, 0);

    s = idle(); s.sv = 1'b1; s.wm = 8'h80;
    applyStimulus("save_ovf", s, 32'h0050_0080, 1, 0, 0, 0, 0, 0);
    s = idle();
    applyStimulus("ovf_pulse", s, 32'h0050_0080, 1, 0, 1, 0, 0, 0);
    s = idle(); s.sv = 1'b1;
    applyStimulus("save_ok", s, 32'h0050_0080, 1, 0, 0, 0, 0, 0);
    s = idle(); s.rs = 1'b1;
    applyStimulus("cwp_wrap7", s, 32'h0050_0087, 1, 0, 0, 0, 0, 0);
    s = idle();
    applyStimulus("cwp_wrap0", s, 32'h0050_0080, 1, 0, 0, 0, 0, 0);
    s = idle(); s.rs = 1'b1; s.wm = 8'h02;
    applyStimulus("rest_unf", s, 32'h0050_0080, 1, 0, 0, 0, 0, 0);
    s = idle();
    applyStimulus("unf_pulse", s, 32'h0050_0080, 1, 0, 0, 1, 0, 0);
    s = idle(); s.sv = 1'b1; s.rs = 1'b1;
    applyStimulus("save_rest", s, 32'h0050_0080, 1, 0, 0, 0, 0, 0);
    s = idle();
    applyStimulus("sr_none", s, 32'h0050_0080, 1, 0, 0, 0, 0, 0);

    s = idle(); s.wr = 1'b1; s.wd = 32'h0000_0023;
    applyStimulus("wr_setup", s, 32'h0050_0080, 1, 0, 0, 0, 0, 0);
    s = idle(); s.trap = 1'b1;
    applyStimulus("trap1", s, 32'h0000_0023, 0, 0, 0, 0, 0, 0);
    s = idle(); s.rt = 1'b1;
    applyStimulus("rett1", s, 32'h0000_0082, 0, 0, 0, 0, 0, 0);
    s = idle(); s.trap = 1'b1;
    applyStimulus("trap2", s, 32'h0000_0023, 0, 0, 0, 0, 0, 0);
    s = idle(); s.trap = 1'b1;
    applyStimulus("trap_et0", s, 32'h0000_0082, 0, 0, 0, 0, 0, 0);
    s = idle();
    applyStimulus("err_set", s, 32'h0000_0082, 0, 0, 0, 0, 0, 1);

    s = idle(); s.wr = 1'b1; s.wd = 32'h00F0_0FA5;
    applyStimulus("wr_full", s, 32'h0000_0082, 0, 0, 0, 0, 0, 1);
    s = idle(); s.wr = 1'b1; s.wd = 32'h0000_0009; s.cnd = 4'h7;
    applyStimulus("wr_ill", s, 32'h00F0_0FA5, 1, 1, 0, 0, 0, 1);
    s = idle();
    applyStimulus("ill_pulse", s, 32'h00F0_0FA5, 1, 0, 0, 0, 1, 1);
    s = idle(); s.wr = 1'b1; s.wd = 32'h0000_0021;
    s.we = 1'b1; s.n = 1'b1; s.z = 1'b1; s.c = 1'b1; s.v = 1'b1;
    applyStimulus("wr_vs_we", s, 32'h00F0_0FA5, 1, 0, 0, 0, 0, 1);
    s = idle(); s.cnd = 4'h6;
    applyStimulus("wr_wins", s, 32'h0000_0021, 0, 0, 0, 0, 0, 1);

    s = idle(); s.rst = 1'b1; s.sv = 1'b1; s.wm = 8'h01;
    applyStimulus("save_rst", s, 32'h0000_0021, 0, 0, 0, 0, 0, 1);
    s = idle();
    applyStimulus("post_rst", s, 32'h0000_0080, 0, 0, 0, 0, 0, 0);

    s = idle(); s.we = 1'b1; s.z = 1'b1; s.cnd = 4'h1;
    applyStimulus("bypass", s, 32'h0000_0080, 0, BYP, 0, 0, 0, 0);
    s = idle(); s.cnd = 4'h1;
    applyStimulus("bypass_reg", s, 32'h0040_0080, 0, 1, 0, 0, 0, 0);

    stim_done = 1'b1;
    repeat (3) @(posedge clk);
    if (expq.size() != 0) begin
      checks++;
      $display("[TB] FAIL drain: %0d expectations never checked, required 0", expq.size());
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
